// File: rtl/axi_slave_pkg.sv
// Shared AXI slave definitions: burst/response codes, FSM states, descriptor control fields.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
// Contents: BURST_* and RESP_* codes, state_t, desc_t, wrap_len_ok().
package axi_slave_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Width-independent part of a captured write descriptor.
  typedef struct packed {
    logic [2:0] size;     // log2 bytes per beat
    logic [1:0] burst;    // FIXED / INCR / WRAP / reserved
    logic       no_write; // whole burst is drained without touching memory
  } desc_t;

  // WRAP bursts are only legal for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [31:0] len);
    return (len == 32'd1) || (len == 32'd3) || (len == 32'd7) || (len == 32'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-beat address and byte-lane mask generator for AXI FIXED/INCR/WRAP bursts.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to advance to next_addr.
// Ports: addr/size/len/burst describe the current beat; next_addr is the following
// beat's byte address, lane_mask enables bytes from addr up to the end of its 2^size container.
module axi_burst_addr_gen
  import axi_slave_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADD_WIDTH  = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic [ADD_WIDTH-1:0]    addr,
  input  logic [2:0]              size,
  input  logic [LEN_WIDTH-1:0]    len,
  input  logic [1:0]              burst,
  output logic [ADD_WIDTH-1:0]    next_addr,
  output logic [DATA_WIDTH/8-1:0] lane_mask
);

  localparam int STRB = DATA_WIDTH / 8;
  localparam logic [ADD_WIDTH-1:0] BUS_MASK = ADD_WIDTH'(STRB - 1);

  logic [ADD_WIDTH-1:0] size_bytes;
  logic [ADD_WIDTH-1:0] aligned;
  logic [ADD_WIDTH-1:0] incr_addr;
  logic [ADD_WIDTH-1:0] wrap_mask;
  logic [ADD_WIDTH-1:0] wrap_addr;
  logic [ADD_WIDTH-1:0] lane_lo;
  logic [ADD_WIDTH-1:0] lane_hi;

  always_comb begin
    size_bytes = ADD_WIDTH'(1) << size;
    aligned    = addr & ~(size_bytes - ADD_WIDTH'(1));
    incr_addr  = aligned + size_bytes;
    // Container of (len+1) beats; the wrapped address keeps the container base
    // and takes only the in-container offset from the incremented address.
    wrap_mask  = ((ADD_WIDTH'(len) + ADD_WIDTH'(1)) << size) - ADD_WIDTH'(1);
    wrap_addr  = (addr & ~wrap_mask) | (incr_addr & wrap_mask);

    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = wrap_len_ok(32'(len)) ? wrap_addr : incr_addr;
      default:     next_addr = incr_addr;
    endcase

    // Enabled lanes: from the (possibly unaligned) start byte to the end of the
    // size-aligned container, both measured within the bus word.
    lane_lo   = addr & BUS_MASK;
    lane_hi   = (aligned & BUS_MASK) + size_bytes;
    lane_mask = '0;
    for (int b = 0; b < STRB; b++) begin
      lane_mask[b] = (ADD_WIDTH'(b) >= lane_lo) && (ADD_WIDTH'(b) < lane_hi);
    end
  end

endmodule

// File: rtl/axi_wdata_slave.sv
// AXI write-data slave: takes one burst descriptor, drains its W beats into a byte-enabled memory port, returns B.
// Latency: memory write one cycle after each accepted beat; bvalid the cycle after the last beat.
// Backpressure: desc_ready only in IDLE, wready only in DATA (one beat/cycle), bvalid holds until bready.
// Ports: desc_* descriptor in; w* data in; b* response out; mem_* synchronous write port; err_wlast pulse.
// Build option: define WLAST_CHECK_EN to check wlast against the beat counter (else err_wlast is 0).
module axi_wdata_slave
  import axi_slave_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADD_WIDTH  = 32,
  parameter int ID_WIDTH   = 4,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    desc_valid,
  output logic                    desc_ready,
  input  logic [ADD_WIDTH-1:0]    desc_addr,
  input  logic [ID_WIDTH-1:0]     desc_id,
  input  logic [LEN_WIDTH-1:0]    desc_len,
  input  logic [2:0]              desc_size,
  input  logic [1:0]              desc_burst,
  input  logic [ID_WIDTH-1:0]     wid,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  output logic                    mem_we,
  output logic [ADD_WIDTH-1:0]    mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic                    err_wlast
);

  localparam int STRB    = DATA_WIDTH / 8;
  localparam int BUS_LSB = $clog2(STRB);
  localparam logic [ADD_WIDTH-1:0] BUS_MASK = ADD_WIDTH'(STRB - 1);

  state_t                 state_q, state_d;
  desc_t                  ctl_q, ctl_d;
  logic [ADD_WIDTH-1:0]   addr_q, addr_d;
  logic [ID_WIDTH-1:0]    id_q, id_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
  logic [1:0]             resp_q, resp_d;

  logic                   desc_ready_d, wready_d, bvalid_d;
  logic [ID_WIDTH-1:0]    bid_d;
  logic [1:0]             bresp_d;
  logic                   mem_we_d;
  logic [ADD_WIDTH-1:0]   mem_addr_d;
  logic [DATA_WIDTH-1:0]  mem_wdata_d;
  logic [STRB-1:0]        mem_be_d;
  logic                   err_wlast_d;

  logic [ADD_WIDTH-1:0]   next_addr;
  logic [STRB-1:0]        lane_mask;
  logic                   size_err;

`ifndef WLAST_CHECK_EN
  logic unused_wlast;
  assign unused_wlast = wlast;
`endif

  axi_burst_addr_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADD_WIDTH  (ADD_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_addr_gen (
    .addr      (addr_q),
    .size      (ctl_q.size),
    .len       (len_q),
    .burst     (ctl_q.burst),
    .next_addr (next_addr),
    .lane_mask (lane_mask)
  );

  // Beats wider than the bus cannot be placed on the memory port.
  assign size_err = ({29'd0, desc_size} > 32'(BUS_LSB));

  always_comb begin
    state_d     = state_q;
    ctl_d       = ctl_q;
    addr_d      = addr_q;
    id_d        = id_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    resp_d      = resp_q;
    bid_d       = bid;
    bresp_d     = bresp;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_be_d    = mem_be;
    err_wlast_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (desc_valid && desc_ready) begin
          addr_d         = desc_addr;
          id_d           = desc_id;
          len_d          = desc_len;
          cnt_d          = desc_len;
          ctl_d.size     = desc_size;
          ctl_d.burst    = desc_burst;
          ctl_d.no_write = size_err || (desc_burst == BURST_RSVD);
          // An illegal WRAP length is still written (as INCR) but reported.
          if (size_err || (desc_burst == BURST_RSVD) ||
              ((desc_burst == BURST_WRAP) && !wrap_len_ok(32'(desc_len)))) begin
            resp_d = RESP_SLVERR;
          end else begin
            resp_d = RESP_OKAY;
          end
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (wvalid && wready) begin
          mem_we_d    = !ctl_q.no_write && (wid == id_q);
          mem_addr_d  = addr_q & ~BUS_MASK;
          mem_wdata_d = wdata;
          mem_be_d    = wstrb & lane_mask;
          if (wid != id_q) begin
            resp_d = RESP_SLVERR;
          end
`ifdef WLAST_CHECK_EN
          if (wlast != (cnt_q == '0)) begin
            err_wlast_d = 1'b1;
            resp_d      = RESP_SLVERR;
          end
`endif
          // The counter alone ends the burst, so it never wraps below zero.
          if (cnt_q == '0) begin
            bid_d   = id_q;
            bresp_d = resp_d;
            state_d = ST_RESP;
          end else begin
            cnt_d  = cnt_q - LEN_WIDTH'(1);
            addr_d = next_addr;
          end
        end
      end

      ST_RESP: begin
        if (bvalid && bready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Handshake outputs are registered copies of the next state.
    desc_ready_d = (state_d == ST_IDLE);
    wready_d     = (state_d == ST_DATA);
    bvalid_d     = (state_d == ST_RESP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ctl_q      <= '0;
      addr_q     <= '0;
      id_q       <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      resp_q     <= RESP_OKAY;
      desc_ready <= 1'b0;
      wready     <= 1'b0;
      bvalid     <= 1'b0;
      bid        <= '0;
      bresp      <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      err_wlast  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctl_q      <= ctl_d;
      addr_q     <= addr_d;
      id_q       <= id_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      resp_q     <= resp_d;
      desc_ready <= desc_ready_d;
      wready     <= wready_d;
      bvalid     <= bvalid_d;
      bid        <= bid_d;
      bresp      <= bresp_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      mem_be     <= mem_be_d;
      err_wlast  <= err_wlast_d;
    end
  end

endmodule
